// File: rtl/serial_adder_seq_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM encoding, pin bit IDs
// and the counter-width helper.
package serial_adder_seq_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StRun  = ST_RUN,
      StDone = ST_DONE
   } state_e;

   // Pin positions on the wrapper's io_in / io_out buses
   localparam int unsigned I_CLK_BITID   = 0;
   localparam int unsigned I_RESET_BITID = 1;
   localparam int unsigned I_A_BITID     = 2;
   localparam int unsigned I_B_BITID     = 3;
   localparam int unsigned I_START_BITID = 4;
   localparam int unsigned O_VALID_BITID = 4;
   localparam int unsigned O_DONE_BITID  = 5;
   localparam int unsigned O_CARRY_BITID = 6;
   localparam int unsigned O_SUM_BITID   = 7;

   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_seq_if.sv
// Operand/result bundle of the serial adder. With SERIAL_ADDER_SUB_EN defined a
// sub (subtract) request line is added.
interface serial_adder_seq_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic             start;
   logic             a;
   logic             b;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             s;
   logic             s_valid;
   logic             c;
   logic             done;
   logic             busy;
   logic [WIDTH-1:0] sum;

   modport master (
`ifdef SERIAL_ADDER_SUB_EN
      output sub,
`endif
      output start, a, b,
      input  s, s_valid, c, done, busy, sum
   );

   modport slave (
`ifdef SERIAL_ADDER_SUB_EN
      input  sub,
`endif
      input  start, a, b,
      output s, s_valid, c, done, busy, sum
   );
endinterface

// File: rtl/serial_adder_seq_fulladder.sv
// One-bit full adder slice used for each serial bit step.
module serial_adder_seq_fulladder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);
   assign o_s    = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial adder sequencer: LSB-first operands, serial and parallel sum, final carry.
// Optional subtract mode is enabled with the SERIAL_ADDER_SUB_EN macro.
module serial_adder_seq
   import serial_adder_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   serial_adder_seq_if.slave bus
);
   localparam int unsigned   CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_e           r_state;
   logic             r_cy;
   logic [CW-1:0]    r_cnt;
   logic             r_s;
   logic             r_s_valid;
   logic             r_c;
   logic             r_done;
   logic             r_busy;
   logic [WIDTH-1:0] r_sum;

   logic             w_b_eff;
   logic             w_cy_init;
   logic             w_s_next;
   logic             w_cy_next;
   logic [WIDTH-1:0] w_sum_next;

`ifdef SERIAL_ADDER_SUB_EN
   logic r_sub;

   // Subtract mode is latched with start and held for the whole operation
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sub <= 1'b0;
      end else if (bus.start && (r_state != StRun)) begin
         r_sub <= bus.sub;
      end
   end

   assign w_b_eff   = bus.b ^ r_sub;
   assign w_cy_init = bus.sub;
`else
   assign w_b_eff   = bus.b;
   assign w_cy_init = 1'b0;
`endif

   serial_adder_seq_fulladder u_fa (
      .i_a    (bus.a),
      .i_b    (w_b_eff),
      .i_cin  (r_cy),
      .o_s    (w_s_next),
      .o_cout (w_cy_next)
   );

   if (WIDTH > 1) begin : g_shift
      assign w_sum_next = {w_s_next, r_sum[WIDTH-1:1]};
   end else begin : g_single
      assign w_sum_next = w_s_next;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= StIdle;
         r_cy      <= 1'b0;
         r_cnt     <= '0;
         r_s       <= 1'b0;
         r_s_valid <= 1'b0;
         r_c       <= 1'b0;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
         r_sum     <= '0;
      end else begin
         case (r_state)
            StRun: begin
               r_s       <= w_s_next;
               r_s_valid <= 1'b1;
               r_sum     <= w_sum_next;
               r_cy      <= w_cy_next;
               if (r_cnt == LAST_CNT) begin
                  r_state <= StDone;
                  r_c     <= w_cy_next;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               // IDLE and DONE share the exit path; DONE may restart without a bubble
               r_done    <= 1'b0;
               r_c       <= 1'b0;
               r_s_valid <= 1'b0;
               if (bus.start) begin
                  r_state <= StRun;
                  r_cy    <= w_cy_init;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= StIdle;
               end
            end
         endcase
      end
   end

   assign bus.s       = r_s;
   assign bus.s_valid = r_s_valid;
   assign bus.c       = r_c;
   assign bus.done    = r_done;
   assign bus.busy    = r_busy;
   assign bus.sum     = r_sum;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed, table-driven bench for serial_adder_seq (WIDTH=8); adds subtract vectors
// when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_seq;
   localparam int unsigned W = 8;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      int         pulse_at;
      logic [7:0] sum;
      logic       c;
   } vec_t;

   logic  clk = 1'b0;
   logic  rst;
   vec_t  vecs[10];
   int    n_vec;
   int    n_cmp = 0;
   int    n_bad = 0;
   string cur = "init";
   vec_t  v_chain0, v_chain1, v_rst0, v_rst1;

   always #5 clk = ~clk;

   serial_adder_seq_if #(.WIDTH(W)) bus ();

   serial_adder_seq #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s/%s: got %0h expected %0h", cur, nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_s"}, bus.s, 0);
      chk({nm, "_svalid"}, bus.s_valid, 0);
      chk({nm, "_c"}, bus.c, 0);
      chk({nm, "_done"}, bus.done, 0);
      chk({nm, "_busy"}, bus.busy, 0);
      chk({nm, "_sum"}, bus.sum, 0);
   endtask

   // Called #1 after a clock edge; returns #1 after the start edge
   task automatic start_op(input vec_t v);
      bus.start = 1'b1;
      bus.a     = 1'b0;
      bus.b     = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub   = v.sub;
`endif
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("start_busy", bus.busy, 1);
      chk("start_done", bus.done, 0);
      chk("start_svalid", bus.s_valid, 0);
   endtask

   task automatic run_body(input vec_t v, input bit chain);
      int nv = 0;
      for (int i = 0; i < int'(W); i++) begin
         bus.a     = v.a[i];
         bus.b     = v.b[i];
         bus.start = (i == v.pulse_at);
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         chk($sformatf("s_bit%0d", i), bus.s, v.sum[i]);
         if (bus.s_valid === 1'b1) nv++;
         chk($sformatf("done_at%0d", i), bus.done, (i == int'(W) - 1));
         chk($sformatf("busy_at%0d", i), bus.busy, (i != int'(W) - 1));
      end
      chk("sum", bus.sum, v.sum);
      chk("carry", bus.c, v.c);
      if (!chain) begin
         @(posedge clk);
         #1;
         if (bus.s_valid === 1'b1) nv++;
         chk("post_done", bus.done, 0);
         chk("post_c", bus.c, 0);
         chk("post_busy", bus.busy, 0);
         chk("post_sum_held", bus.sum, v.sum);
      end
      chk("svalid_count", nv, W);
   endtask

   initial begin
      vecs[0] = '{8'h5A, 8'h3C, 1'b0, -1, 8'h96, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, -1, 8'h00, 1'b1};
      vecs[2] = '{8'h12, 8'h34, 1'b0,  3, 8'h46, 1'b0};
      vecs[3] = '{8'hAA, 8'h55, 1'b0, -1, 8'hFF, 1'b0};
      vecs[4] = '{8'hFF, 8'hFF, 1'b0, -1, 8'hFE, 1'b1};
      vecs[5] = '{8'h00, 8'h00, 1'b0, -1, 8'h00, 1'b0};
      n_vec   = 6;
`ifdef SERIAL_ADDER_SUB_EN
      vecs[6] = '{8'h10, 8'h20, 1'b1, -1, 8'hF0, 1'b0};
      vecs[7] = '{8'h20, 8'h10, 1'b1, -1, 8'h10, 1'b1};
      vecs[8] = '{8'h5A, 8'h5A, 1'b1, -1, 8'h00, 1'b1};
      n_vec   = 9;
`endif
      v_chain0 = '{8'hFF, 8'h01, 1'b0, -1, 8'h00, 1'b1};
      v_chain1 = '{8'h80, 8'h80, 1'b0, -1, 8'h00, 1'b1};
      v_rst0   = '{8'h5A, 8'h3C, 1'b0, -1, 8'h96, 1'b0};
      v_rst1   = '{8'h01, 8'h01, 1'b0, -1, 8'h02, 1'b0};

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = 1'b0;
      bus.b     = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub   = 1'b0;
`endif
      #12;
      chk_all_zero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_busy", bus.busy, 0);

      for (int k = 0; k < n_vec; k++) begin
         cur = $sformatf("vec%0d", k);
         start_op(vecs[k]);
         run_body(vecs[k], 1'b0);
      end

      // Back-to-back: start high in DONE goes straight to RUN with a cleared carry
      cur = "chain0";
      start_op(v_chain0);
      run_body(v_chain0, 1'b1);
      cur = "chain1";
      start_op(v_chain1);
      run_body(v_chain1, 1'b0);

      // Reset mid-operation clears everything without waiting for a clock edge
      cur = "midrst";
      start_op(v_rst0);
      for (int i = 0; i < 5; i++) begin
         bus.a = v_rst0.a[i];
         bus.b = v_rst0.b[i];
         @(posedge clk);
         #1;
      end
      chk("pre_rst_s", bus.s, 1);
      rst = 1'b1;
      #1;
      chk_all_zero("async");
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("after_rst_busy", bus.busy, 0);
      cur = "postrst";
      start_op(v_rst1);
      run_body(v_rst1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
